// File: rtl/io_intr_responder.sv
// Memory-mapped I/O block: byte-wide storage plus a countdown timer whose expiry
// raises an interrupt through an IDLE/PEND/ACK handshake with the CPU.
module io_intr_responder #(
    parameter int unsigned ADDR_W     = 12,
    parameter logic [31:0] RELOAD_RST = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       D_In,
    output wire  [31:0]       D_Out,
    output logic              intr,
    input  logic              inta
);

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_e;

    logic [31:0] addr_ext;
    logic [11:0] base;
    logic        in_range, is_mem, wr_en, rd_en;
    logic        sel_tload, sel_tctrl, sel_tcount, sel_status;
    logic        wr_tctrl, expiry;
    logic [31:0] rdata;

    state_e      state_q, state_d;
    logic [31:0] tload_q, tload_d, tcount_q, tcount_d;
    logic        en_q, en_d, auto_q, auto_d, ovr_q, ovr_d;
    logic        expired_q, expired_d, intr_q, intr_d;

    logic [7:0]  mem [0:4095];

    assign addr_ext   = 32'(Address);
    assign base       = addr_ext[11:0];
    assign in_range   = (addr_ext[31:12] == 20'h0);
    assign is_mem     = in_range && (base < 12'hFF0);
    assign sel_tload  = in_range && (base[11:2] == 10'h3FC);
    assign sel_tctrl  = in_range && (base[11:2] == 10'h3FD);
    assign sel_tcount = in_range && (base[11:2] == 10'h3FE);
    assign sel_status = in_range && (base[11:2] == 10'h3FF);
    assign wr_en      = io_cs & io_wr;
    assign rd_en      = io_cs & io_rd & ~io_wr;
    assign wr_tctrl   = wr_en & sel_tctrl;
    // Expiry is the 1 -> 0 decrement; a TCTRL write on that edge pre-empts it.
    assign expiry     = en_q && (tcount_q == 32'd1) && !wr_tctrl;

    // NOTE: storage has no reset branch so it maps onto RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && is_mem) begin
            mem[base]          <= D_In[31:24];
            mem[base + 12'd1]  <= D_In[23:16];
            mem[base + 12'd2]  <= D_In[15:8];
            mem[base + 12'd3]  <= D_In[7:0];
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (is_mem)
            rdata = {mem[base], mem[base + 12'd1], mem[base + 12'd2], mem[base + 12'd3]};
        else if (sel_tload)  rdata = tload_q;
        else if (sel_tctrl)  rdata = {30'h0, auto_q, en_q};
        else if (sel_tcount) rdata = tcount_q;
        else if (sel_status) rdata = {30'h0, ovr_q, state_q == PEND};
    end

    assign D_Out = rd_en ? rdata : 32'hzzzz_zzzz;
    assign intr  = intr_q;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        tload_d   = tload_q;
        tcount_d  = tcount_q;
        en_d      = en_q;
        auto_d    = auto_q;
        ovr_d     = ovr_q;
        state_d   = state_q;
        expired_d = expiry;

        if (wr_en && sel_tload) tload_d = D_In;

        if (wr_tctrl) begin
            en_d   = D_In[0];
            auto_d = D_In[1];
            if (D_In[0]) tcount_d = tload_q;
        end else if (expired_q) begin
            if (auto_q) tcount_d = tload_q;
            else        en_d     = 1'b0;
        end else if (en_q && (tcount_q != 32'd0)) begin
            tcount_d = tcount_q - 32'd1;
        end

        if (wr_en && sel_status && D_In[1]) ovr_d = 1'b0;

        case (state_q)
            IDLE: if (expiry) state_d = PEND;
            PEND: begin
                if (inta)   state_d = ACK;
                if (expiry) ovr_d   = 1'b1;
            end
            ACK: begin
                if (!inta)       state_d = expiry ? PEND : IDLE;
                else if (expiry) ovr_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        intr_d = (state_d == PEND);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            intr_q    <= 1'b0;
            tload_q   <= RELOAD_RST;
            tcount_q  <= 32'h0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ovr_q     <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            tload_q   <= tload_d;
            tcount_q  <= tcount_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ovr_q     <= ovr_d;
            expired_q <= expired_d;
        end
    end

endmodule

// File: tb/tb_io_intr_responder.sv
// Directed bench for io_intr_responder: storage, register map, timer, interrupt handshake, reset.
module tb_io_intr_responder;

    localparam int unsigned AW     = 16;
    localparam logic [31:0] RELOAD = 32'h0000_0007;
    localparam logic [15:0] A_TLOAD  = 16'h0FF0;
    localparam logic [15:0] A_TCTRL  = 16'h0FF4;
    localparam logic [15:0] A_TCOUNT = 16'h0FF8;
    localparam logic [15:0] A_STATUS = 16'h0FFC;
    // An undriven read bus floats high through the pull, so "Z" is observed as all ones.
    localparam logic [31:0] BUS_Z  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0, inta = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [31:0]   D_In = '0;
    tri1  [31:0]   d_out;
    logic          intr;

    int n_checks = 0;
    int n_errors = 0;

    io_intr_responder #(.ADDR_W(AW), .RELOAD_RST(RELOAD)) dut (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .Address(Address), .D_In(D_In), .D_Out(d_out), .intr(intr), .inta(inta)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        Address = a; io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0;
        #1;
        d = d_out;
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    // Called in the low phase; the write commits on the next rising edge, returns at the following negedge.
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        Address = a; D_In = d; io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0;
        @(negedge clk);
        io_cs = 1'b0; io_wr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;

        // Reset state, read while reset is held
        @(negedge clk);
        check("rst_intr", {31'h0, intr}, 32'h0);
        chk_rd("rst_tcount", A_TCOUNT, 32'h0);
        chk_rd("rst_tctrl", A_TCTRL, 32'h0);
        chk_rd("rst_status", A_STATUS, 32'h0);
        chk_rd("rst_tload", A_TLOAD, RELOAD);
        reset = 1'b1;
        @(negedge clk);

        // Storage, big-endian, boundaries and out-of-range
        wr(16'h0010, 32'hDEAD_BEEF);
        chk_rd("mem_word", 16'h0010, 32'hDEAD_BEEF);
        rd(16'h0010, d);
        check("mem_byte0", {24'h0, d[31:24]}, 32'h0000_00DE);
        wr(16'h0FEC, 32'hA1B2_C3D4);
        chk_rd("mem_top_word", 16'h0FEC, 32'hA1B2_C3D4);
        wr(16'h1010, 32'h5555_5555);
        chk_rd("oor_read", 16'h1010, 32'h0);
        chk_rd("oor_no_alias", 16'h0010, 32'hDEAD_BEEF);

        // Simultaneous read+write: bus floats, write still lands
        Address = 16'h0014; D_In = 32'h1122_3344; io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b1;
        #1;
        check("rdwr_z", d_out, BUS_Z);
        @(negedge clk);
        io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
        chk_rd("rdwr_written", 16'h0014, 32'h1122_3344);

        // Deselected read floats
        Address = 16'h0010; io_rd = 1'b1;
        #1;
        check("cs0_z", d_out, BUS_Z);
        io_rd = 1'b0;

        // One-shot countdown 3,2,1,0 then EN clears
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'd1);
        chk_rd("cnt3", A_TCOUNT, 32'd3);
        check("cnt3_intr", {31'h0, intr}, 32'h0);
        @(negedge clk); chk_rd("cnt2", A_TCOUNT, 32'd2);
        @(negedge clk); chk_rd("cnt1", A_TCOUNT, 32'd1);
        check("cnt1_intr", {31'h0, intr}, 32'h0);
        @(negedge clk); chk_rd("cnt0", A_TCOUNT, 32'd0);
        check("expiry_intr", {31'h0, intr}, 32'h1);
        chk_rd("expiry_status", A_STATUS, 32'h1);
        chk_rd("expiry_en_still", A_TCTRL, 32'h1);
        @(negedge clk); chk_rd("oneshot_en_clr", A_TCTRL, 32'h0);

        // Acknowledge handshake
        inta = 1'b1;
        @(negedge clk);
        check("ack_intr_low", {31'h0, intr}, 32'h0);
        chk_rd("ack_status", A_STATUS, 32'h0);
        inta = 1'b0;
        @(negedge clk);
        check("idle_intr", {31'h0, intr}, 32'h0);
        wr(A_TCOUNT, 32'h99);
        chk_rd("tcount_ro", A_TCOUNT, 32'h0);
        inta = 1'b1;
        repeat (2) @(negedge clk);
        inta = 1'b0;
        check("idle_inta_ignored", {31'h0, intr}, 32'h0);

        // Auto-reload, overrun, OVR clear, TCTRL write priority
        wr(A_TLOAD, 32'd2);
        wr(A_TCTRL, 32'd3);
        chk_rd("auto_cnt2", A_TCOUNT, 32'd2);
        @(negedge clk); chk_rd("auto_cnt1", A_TCOUNT, 32'd1);
        @(negedge clk); check("auto_exp1_intr", {31'h0, intr}, 32'h1);
        chk_rd("auto_exp1_status", A_STATUS, 32'h1);
        @(negedge clk); chk_rd("auto_reload", A_TCOUNT, 32'd2);
        chk_rd("auto_tctrl", A_TCTRL, 32'h3);
        @(negedge clk);
        @(negedge clk); chk_rd("ovr_status", A_STATUS, 32'h3);
        wr(A_STATUS, 32'h2);
        chk_rd("ovr_cleared", A_STATUS, 32'h1);
        chk_rd("reload_after_exp2", A_TCOUNT, 32'd2);
        wr(A_TCTRL, 32'h0);
        chk_rd("tctrl_priority", A_TCOUNT, 32'd2);
        @(negedge clk); chk_rd("stopped", A_TCOUNT, 32'd2);
        inta = 1'b1; @(negedge clk);
        inta = 1'b0; @(negedge clk);
        chk_rd("ack2_status", A_STATUS, 32'h0);

        // Expiry on the ACK -> IDLE edge goes straight to PEND
        wr(A_TLOAD, 32'd4);
        wr(A_TCTRL, 32'd3);
        repeat (4) @(negedge clk);
        check("x1_intr", {31'h0, intr}, 32'h1);
        inta = 1'b1;
        @(negedge clk);
        check("x1_acked", {31'h0, intr}, 32'h0);
        chk_rd("x1_reload", A_TCOUNT, 32'd4);
        repeat (3) @(negedge clk);
        chk_rd("x2_cnt1", A_TCOUNT, 32'd1);
        inta = 1'b0;
        @(negedge clk);
        check("ack_expiry_pend", {31'h0, intr}, 32'h1);
        chk_rd("ack_expiry_status", A_STATUS, 32'h1);
        wr(A_TCTRL, 32'h0);
        inta = 1'b1; @(negedge clk);
        inta = 1'b0; @(negedge clk);

        // TLOAD = 0 never expires; TCTRL reserved bits read 0
        wr(A_TLOAD, 32'd0);
        wr(A_TCTRL, 32'hFFFF_FFFF);
        chk_rd("tctrl_mask", A_TCTRL, 32'h3);
        repeat (4) @(negedge clk);
        check("zero_load_no_intr", {31'h0, intr}, 32'h0);
        chk_rd("zero_load_cnt", A_TCOUNT, 32'h0);
        chk_rd("zero_load_en", A_TCTRL, 32'h3);
        wr(A_TCTRL, 32'h0);

        // Asynchronous reset mid-countdown with an interrupt pending
        wr(A_TLOAD, 32'd1);
        wr(A_TCTRL, 32'd1);
        @(negedge clk);
        @(negedge clk);
        wr(A_TLOAD, 32'd5);
        wr(A_TCTRL, 32'd1);
        chk_rd("pre_rst_cnt", A_TCOUNT, 32'd5);
        check("pre_rst_intr", {31'h0, intr}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_intr", {31'h0, intr}, 32'h0);
        chk_rd("async_rst_cnt", A_TCOUNT, 32'h0);
        chk_rd("async_rst_status", A_STATUS, 32'h0);
        chk_rd("async_rst_tctrl", A_TCTRL, 32'h0);
        chk_rd("async_rst_tload", A_TLOAD, RELOAD);
        chk_rd("mem_survives_rst", 16'h0010, 32'hDEAD_BEEF);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_rd("post_rst_cnt", A_TCOUNT, 32'h0);
        check("post_rst_intr", {31'h0, intr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
